// File: rtl/tt_io_bridge_if.sv
// Pad-side signal bundle between the Tiny Tapeout wrapper/fpga_top and tt_io_bridge.
// master drives the raw pins and LED/PWM controls; slave is the bridge itself.
interface tt_io_bridge_if #(
  parameter int unsigned NUM_IRQ  = 2,
  parameter int unsigned LED_CH   = 6,
  parameter int unsigned PWM_BITS = 4
);
  logic                rx_pin;
  logic                rx_sync;
  logic [NUM_IRQ-1:0]  irq_pin;
  logic [NUM_IRQ-1:0]  irq_edge_mode;
  logic [NUM_IRQ-1:0]  irq_ack;
  logic [NUM_IRQ-1:0]  irq_out;
  logic [LED_CH-1:0]   led_in;
  logic                pwm_en;
  logic [PWM_BITS-1:0] pwm_duty;
  logic [LED_CH-1:0]   led_out;

  modport master (
    output rx_pin, irq_pin, irq_edge_mode, irq_ack, led_in, pwm_en, pwm_duty,
    input  rx_sync, irq_out, led_out
  );

  modport slave (
    input  rx_pin, irq_pin, irq_edge_mode, irq_ack, led_in, pwm_en, pwm_duty,
    output rx_sync, irq_out, led_out
  );
endinterface

// File: rtl/tt_io_bridge.sv
// Pin conditioning: rx synchroniser, per-channel irq sync/debounce with edge or level
// reporting, and a global PWM dimmer on the LED outputs.
module tt_io_bridge #(
  parameter int unsigned NUM_IRQ     = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned LED_CH      = 6,
  parameter int unsigned PWM_BITS    = 4
) (
  input logic          clk,
  input logic          rst_n,
  tt_io_bridge_if.slave io
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] DebMax = CntW'(DEB_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] PwmMax = '1;

  // rx synchroniser resets to 1 so the UART sees an idle line.
  logic [SYNC_STAGES-1:0] rx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q <= '1;
    end else begin
      rx_q <= {rx_q[SYNC_STAGES-2:0], io.rx_pin};
    end
  end

  assign io.rx_sync = rx_q[SYNC_STAGES-1];

  logic [NUM_IRQ-1:0] irq_out;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_irq
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   pend_q, pend_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      cnt_d  = cnt_q;
      lvl_d  = lvl_q;
      pend_d = pend_q;
      if (s == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == DebMax) begin
        lvl_d = s;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
      // A new debounced rise outranks a simultaneous ack so no event is lost.
      if (!io.irq_edge_mode[i]) begin
        pend_d = 1'b0;
      end else if (lvl_d && !lvl_q) begin
        pend_d = 1'b1;
      end else if (io.irq_ack[i]) begin
        pend_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], io.irq_pin[i]};
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
        pend_q <= pend_d;
      end
    end

    assign irq_out[i] = io.irq_edge_mode[i] ? pend_q : lvl_q;
  end

  assign io.irq_out = irq_out;

  // PWM: duty is sampled only at the end of a period so a period never glitches.
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [LED_CH-1:0]   led_q, led_d;
  logic                pwm_on;

  always_comb begin
    pwm_on = (duty_q == PwmMax) || (cnt_q < duty_q);
    cnt_d  = cnt_q + PWM_BITS'(1);
    duty_d = (cnt_q == PwmMax) ? io.pwm_duty : duty_q;
    led_d  = io.pwm_en ? (io.led_in & {LED_CH{pwm_on}}) : io.led_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      led_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      led_q  <= led_d;
    end
  end

  assign io.led_out = led_q;

endmodule

// File: tb/tb_tt_io_bridge.sv
// Randomised scoreboard bench for tt_io_bridge against a behavioural model built from
// sample histories, run lengths and period arithmetic.
module tb_tt_io_bridge;

  localparam int unsigned NI   = 2;
  localparam int unsigned SS   = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned LC   = 6;
  localparam int unsigned PB   = 4;
  localparam int          PER  = 1 << PB;
  localparam int          NCYC = 1500;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  tt_io_bridge_if #(.NUM_IRQ(NI), .LED_CH(LC), .PWM_BITS(PB)) bus ();

  tt_io_bridge #(
    .NUM_IRQ(NI), .SYNC_STAGES(SS), .DEB_CYCLES(DEB), .LED_CH(LC), .PWM_BITS(PB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  typedef struct {
    logic          rx;
    logic [NI-1:0] irq;
    logic [LC-1:0] led;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 0;

  // Reference model state
  bit rx_hist[$];
  bit irq_hist[NI][$];
  int run_len[NI];
  bit lvl[NI];
  bit pend[NI];
  int cyc;
  int duty_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    rx_hist = {};
    for (int k = 0; k < SS; k++) rx_hist.push_back(1'b1);
    for (int i = 0; i < NI; i++) begin
      irq_hist[i] = {};
      for (int k = 0; k < SS; k++) irq_hist[i].push_back(1'b0);
      run_len[i] = 0;
      lvl[i]     = 1'b0;
      pend[i]    = 1'b0;
    end
    cyc      = 0;
    duty_lat = 0;
  endtask

  // Predict outputs after the coming rising edge from the inputs currently driven.
  task automatic model_edge();
    exp_t e;
    bit   tmp, s, old;
    int   p;
    bit   on;
    if (!rst_n) begin
      model_reset();
      e.rx  = 1'b1;
      e.irq = '0;
      e.led = '0;
      sbq.push_back(e);
      return;
    end
    rx_hist.push_back(bus.rx_pin);
    tmp  = rx_hist.pop_front();
    e.rx = rx_hist[0];
    for (int i = 0; i < NI; i++) begin
      s = irq_hist[i][0];
      irq_hist[i].push_back(bus.irq_pin[i]);
      tmp = irq_hist[i].pop_front();
      old = lvl[i];
      // Accept a new level once it has differed for DEB consecutive samples.
      run_len[i] = (s != lvl[i]) ? run_len[i] + 1 : 0;
      if (run_len[i] == DEB) begin
        lvl[i]     = s;
        run_len[i] = 0;
      end
      if (!bus.irq_edge_mode[i]) pend[i] = 1'b0;
      else if (lvl[i] && !old) pend[i] = 1'b1;
      else if (bus.irq_ack[i]) pend[i] = 1'b0;
      e.irq[i] = bus.irq_edge_mode[i] ? pend[i] : lvl[i];
    end
    p     = cyc % PER;
    on    = (duty_lat == PER - 1) || (p < duty_lat);
    e.led = bus.pwm_en ? (on ? bus.led_in : '0) : bus.led_in;
    if (p == PER - 1) duty_lat = int'(bus.pwm_duty);
    cyc++;
    sbq.push_back(e);
  endtask

  int hold[NI];

  initial begin
    rst_n             = 1'b0;
    bus.rx_pin        = 1'b1;
    bus.irq_pin       = '0;
    bus.irq_edge_mode = '0;
    bus.irq_ack       = '0;
    bus.led_in        = '0;
    bus.pwm_en        = 1'b0;
    bus.pwm_duty      = '0;
    for (int i = 0; i < NI; i++) hold[i] = 0;
    model_reset();

    fork
      begin : driver
        for (int c = 0; c < NCYC; c++) begin
          @(negedge clk);
          if (c == 4 || c == 704) rst_n = 1'b1;
          if (c == 700) rst_n = 1'b0;
          if ($urandom_range(0, 3) == 0) bus.rx_pin = ~bus.rx_pin;
          for (int i = 0; i < NI; i++) begin
            if (hold[i] == 0) begin
              bus.irq_pin[i] = ~bus.irq_pin[i];
              hold[i] = $urandom_range(1, 10);
            end else begin
              hold[i]--;
            end
            bus.irq_ack[i] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) bus.irq_edge_mode[i] = ~bus.irq_edge_mode[i];
          end
          bus.led_in   = LC'($urandom);
          bus.pwm_duty = PB'($urandom);
          if ($urandom_range(0, 39) == 0) bus.pwm_en = ~bus.pwm_en;
          if (c >= 200 && c < 260) begin
            bus.pwm_en = 1'b1; bus.pwm_duty = '0; bus.led_in = '1;
          end else if (c >= 300 && c < 360) begin
            bus.pwm_en = 1'b1; bus.pwm_duty = '1; bus.led_in = '1;
          end else if (c >= 400 && c < 450) begin
            bus.pwm_en = 1'b1; bus.pwm_duty = PB'(4); bus.led_in = '1;
          end
          if (c == 2 || c == 700) begin
            #1;
            chk("reset_rx_sync", 32'(bus.rx_sync), 32'd1);
            chk("reset_irq_out", 32'(bus.irq_out), 32'd0);
            chk("reset_led_out", 32'(bus.led_out), 32'd0);
          end
          model_edge();
        end
        done = 1'b1;
      end
      begin : monitor
        exp_t e;
        int   guard = 0;
        while (1) begin
          @(posedge clk);
          #1;
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rx_sync", 32'(bus.rx_sync), 32'(e.rx));
            chk("irq_out", 32'(bus.irq_out), 32'(e.irq));
            chk("led_out", 32'(bus.led_out), 32'(e.led));
          end else if (done) begin
            break;
          end
          guard++;
          if (guard > NCYC + 100) begin
            chk("monitor_timeout", 32'd1, 32'd0);
            break;
          end
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
